// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states, reset instruction word and RISC-V opcodes shared with decode
package fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
endpackage

// File: rtl/inst_fetch_unit_pc_reg.sv
// pc_reg: program counter with external load (priority) and +4 advance
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        inc,
    input  logic [31:0] inc_base,
    output logic [31:0] pc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= load_val;
        else if (inc) pc <= inc_base + 32'd4;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-cycle fetch stage with req/ack memory port and instruction register.
// FETCH_ALIGN_CHECK_EN: reject misaligned fetch targets and raise sticky misalign_err.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_go,
    input  logic        flush,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    output logic        busy,
    output logic        misalign_err
);
    import fetch_pkg::*;
    fetch_state_t state, state_n;
    logic [31:0] target;
    logic        misalign, accept, reject, ack_take;
    assign target   = pc_we ? pc_next : pc_out;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = target[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif
    assign accept   = state == IDLE && fetch_go && !misalign;
    assign reject   = state == IDLE && fetch_go && misalign;
    assign ack_take = state == FETCH && imem_ack && !flush;
    // request is outstanding exactly while not IDLE, so async reset drops it at once
    assign busy     = state != IDLE;
    assign imem_req = busy;
    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_we && !reject),
        .load_val (pc_next),
        .inc      (ack_take),
        .inc_base (imem_addr),
        .pc       (pc_out)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? FETCH : IDLE;
            FETCH:   state_n = imem_ack ? IDLE : (flush ? DRAIN : FETCH);
            DRAIN:   state_n = imem_ack ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            imem_addr  <= RESET_PC;
            inst_out   <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_valid <= 1'b0;
        end else begin
            if (accept) imem_addr <= target & ~32'd3;
            if (ack_take) begin
                inst_out <= imem_rdata;
                inst_pc  <= imem_addr;
            end
            inst_valid <= ack_take ? 1'b1 : (accept || reject || flush) ? 1'b0 : inst_valid;
        end
`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) misalign_err <= 1'b0;
        else if (reject) misalign_err <= 1'b1;
        else if (accept) misalign_err <= 1'b0;
`else
    assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed vectors against a transaction-level fetch model plus literal checks
module tb_inst_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        fetch_go = 1'b0, flush = 1'b0, pc_we = 1'b0, imem_ack = 1'b0;
    logic [31:0] pc_next = '0, imem_rdata = '0;
    logic        imem_req, inst_valid, busy, misalign_err;
    logic [31:0] imem_addr, inst_out, inst_pc, pc_out;
    int errors = 0, checks = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    bit          m_pend, m_drop, m_valid, m_err;
    logic [31:0] m_addr, m_pc, m_ir, m_ipc;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_go(fetch_go), .flush(flush), .pc_we(pc_we),
        .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst_out(inst_out), .inst_pc(inst_pc), .pc_out(pc_out),
        .inst_valid(inst_valid), .busy(busy), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mreset();
        m_pend = 0; m_drop = 0; m_valid = 0; m_err = 0;
        m_addr = 32'h0; m_pc = 32'h0; m_ir = 32'h0000_0013; m_ipc = 32'h0;
    endtask

    // one clock of stimulus; the model advances with the transaction-level rules
    task automatic cyc(input bit go, input bit fl, input bit we, input logic [31:0] nxt,
                       input bit ack, input logic [31:0] rd);
        logic [31:0] tgt;
        fetch_go = go; flush = fl; pc_we = we; pc_next = nxt; imem_ack = ack; imem_rdata = rd;
        @(posedge clk);
        if (!m_pend) begin
            tgt = we ? nxt : m_pc;
            if (go && ALIGN && tgt[1:0] != 2'b00) begin
                m_err = 1; m_valid = 0;
            end else begin
                if (we) m_pc = nxt;
                if (go) begin
                    m_pend = 1; m_drop = 0; m_valid = 0; m_err = 0;
                    m_addr = {tgt[31:2], 2'b00};
                end
            end
            if (fl) m_valid = 0;
        end else begin
            if (fl) begin m_drop = 1; m_valid = 0; end
            if (ack) begin
                m_pend = 0;
                if (!m_drop) begin
                    m_ir = rd; m_ipc = m_addr; m_valid = 1; m_pc = m_addr + 32'd4;
                end
            end
            if (we) m_pc = nxt;
        end
        #1;
    endtask

    always @(negedge clk)
        if (!rst) begin
            chk("req", imem_req, m_pend);
            chk("busy", busy, m_pend);
            chk("addr", imem_addr, m_addr);
            chk("inst_out", inst_out, m_ir);
            chk("inst_pc", inst_pc, m_ipc);
            chk("pc_out", pc_out, m_pc);
            chk("inst_valid", inst_valid, m_valid);
            chk("misalign_err", misalign_err, m_err);
        end

    initial begin
        mreset();
        #12 rst = 1'b0;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ir", inst_out, 32'h0000_0013);
        chk("rst_valid", inst_valid, 0);
        chk("rst_req", imem_req, 0);
        // minimum latency fetch
        cyc(1, 0, 0, 0, 0, 0);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'h0050_0093);
        chk("t1_ir", inst_out, 32'h0050_0093);
        chk("t1_valid", inst_valid, 1);
        chk("t1_pc", pc_out, 32'h4);
        // delayed ack with ignored fetch_go pulses
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("t2_req", imem_req, 1);
            chk("t2_addr", imem_addr, 32'h4);
        end
        cyc(0, 0, 0, 0, 1, 32'h00A0_0113);
        chk("t2_pc", pc_out, 32'h8);
        chk("t2_ipc", inst_pc, 32'h4);
        // redirected fetch
        cyc(1, 0, 1, 32'h100, 0, 0);
        chk("t3_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 0, 1, 32'h0000_0513);
        chk("t3_pc", pc_out, 32'h104);
        chk("t3_ipc", inst_pc, 32'h100);
        // flush then late ack is discarded
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t4_busy", busy, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t4_ir", inst_out, 32'h0000_0513);
        chk("t4_valid", inst_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_pc", pc_out, 32'h104);
        // async reset mid-fetch
        cyc(1, 0, 0, 0, 0, 0);
        chk("t5_req_pre", imem_req, 1);
        rst = 1'b1;
        #1;
        chk("t5_req", imem_req, 0);
        chk("t5_ir", inst_out, 32'h0000_0013);
        chk("t5_pc", pc_out, 32'h0);
        mreset();
        @(negedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        chk("t5_late_ack", inst_out, 32'h0000_0013);
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("t5_pcload", pc_out, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1, 32'h0000_0093);
        chk("t5_wrap", pc_out, 32'h0);
        chk("t5_ipc", inst_pc, 32'hFFFF_FFFC);
`ifdef FETCH_ALIGN_CHECK_EN
        cyc(1, 0, 1, 32'h102, 0, 0);
        chk("t6_req", imem_req, 0);
        chk("t6_err", misalign_err, 1);
        chk("t6_pc", pc_out, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t6_sticky", misalign_err, 1);
        cyc(1, 0, 1, 32'h200, 0, 0);
        chk("t6_clear", misalign_err, 0);
        chk("t6_addr", imem_addr, 32'h200);
        cyc(0, 0, 0, 0, 1, 32'h0000_0013);
        chk("t6_pc2", pc_out, 32'h204);
`else
        cyc(1, 0, 1, 32'h102, 0, 0);
        chk("t6_addr", imem_addr, 32'h100);
        chk("t6_err", misalign_err, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0013);
        chk("t6_pc", pc_out, 32'h104);
        chk("t6_ipc", inst_pc, 32'h100);
`endif
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
